// File: rtl/pixel_track_ctrl.sv
// Per-frame colour tracker controller. It scans the pixel stream between
// frame markers. Per frame it accumulates a bounding box or a first-hit
// coordinate, plus a saturating hit count. The result is held behind a
// valid/ack handshake.
module pixel_track_ctrl #(
  parameter int XW       = 11,
  parameter int CW       = 10,
  parameter int CNT_W    = 16,
  parameter int MIN_HITS = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             pix_valid,
  input  logic [XW-1:0]    pix_x,
  input  logic [XW-1:0]    pix_y,
  input  logic [CW-1:0]    pix_r,
  input  logic [CW-1:0]    pix_g,
  input  logic [CW-1:0]    pix_b,
  input  logic [CW-1:0]    thr_r_min,
  input  logic [CW-1:0]    thr_g_max,
  input  logic [CW-1:0]    thr_b_max,
  input  logic             mode,
  input  logic             res_ack,
  output logic             res_valid,
  output logic [XW-1:0]    x_min,
  output logic [XW-1:0]    x_max,
  output logic [XW-1:0]    y_min,
  output logic [XW-1:0]    y_max,
  output logic [CNT_W-1:0] hit_count,
  output logic             found,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {S_WAIT, S_SCAN, S_REPORT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] MIN_HITS_C  = CNT_W'(MIN_HITS);

  state_t            state, state_next;
  logic              match;
  logic              clear_acc;
  logic              load_result;
  logic              mode_lat;

  // Running accumulators and their match-updated values
  logic              acc_any, upd_any;
  logic [XW-1:0]     acc_x_min, acc_x_max, acc_y_min, acc_y_max;
  logic [XW-1:0]     upd_x_min, upd_x_max, upd_y_min, upd_y_max;
  logic [CNT_W-1:0]  acc_cnt, upd_cnt;

  assign match = pix_valid & (pix_r >= thr_r_min) & (pix_g <= thr_g_max) & (pix_b <= thr_b_max);

  // A start in S_SCAN restarts the frame, unless frame_end arrives in the same cycle
  assign clear_acc   = frame_start & ((state == S_WAIT) | ((state == S_SCAN) & ~frame_end));
  assign load_result = (state == S_SCAN) & frame_end;

  assign busy      = (state == S_SCAN);
  assign res_valid = (state == S_REPORT);

  // State register
  always_ff @(posedge clock) begin
    if (!resetN) state <= S_WAIT;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_WAIT:   if (frame_start) state_next = S_SCAN;
      S_SCAN:   if (frame_end)   state_next = S_REPORT;
      S_REPORT: if (res_ack)     state_next = S_WAIT;
      default:  state_next = S_WAIT;
    endcase
  end

  // Accumulator update for the current pixel. It also feeds the result load,
  // so a match in the frame_end cycle is included.
  always_comb begin
    upd_any   = acc_any;
    upd_x_min = acc_x_min;
    upd_x_max = acc_x_max;
    upd_y_min = acc_y_min;
    upd_y_max = acc_y_max;
    upd_cnt   = acc_cnt;
    if (match) begin
      upd_any = 1'b1;
      if (acc_cnt != CNT_MAX) upd_cnt = acc_cnt + CNT_W'(1);
      if (!acc_any) begin
        upd_x_min = pix_x;
        upd_x_max = pix_x;
        upd_y_min = pix_y;
        upd_y_max = pix_y;
      end else if (!mode_lat) begin
        if (pix_x < acc_x_min) upd_x_min = pix_x;
        if (pix_x > acc_x_max) upd_x_max = pix_x;
        if (pix_y < acc_y_min) upd_y_min = pix_y;
        if (pix_y > acc_y_max) upd_y_max = pix_y;
      end
    end
  end

  // Accumulator registers: clear on a frame (re)start, track matches while scanning
  always_ff @(posedge clock) begin
    if (!resetN || clear_acc) begin
      acc_any   <= 1'b0;
      acc_x_min <= '0;
      acc_x_max <= '0;
      acc_y_min <= '0;
      acc_y_max <= '0;
      acc_cnt   <= '0;
      mode_lat  <= resetN ? mode : 1'b0;
    end else if (state == S_SCAN) begin
      acc_any   <= upd_any;
      acc_x_min <= upd_x_min;
      acc_x_max <= upd_x_max;
      acc_y_min <= upd_y_min;
      acc_y_max <= upd_y_max;
      acc_cnt   <= upd_cnt;
    end
  end

  // Result registers: capture on the scan-to-report transition, then hold
  always_ff @(posedge clock) begin
    if (!resetN) begin
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      hit_count <= '0;
      found     <= 1'b0;
    end else if (load_result) begin
      x_min     <= upd_x_min;
      x_max     <= upd_x_max;
      y_min     <= upd_y_min;
      y_max     <= upd_y_max;
      hit_count <= upd_cnt;
      found     <= (upd_cnt >= MIN_HITS_C);
    end
  end

  // Sticky overrun: a new frame arrived while the last result was still unacknowledged
  always_ff @(posedge clock) begin
    if (!resetN)                                overrun <= 1'b0;
    else if ((state == S_REPORT) && frame_start) overrun <= 1'b1;
  end

endmodule
